// File: rtl/alpha_tensor_issue_queue.sv
// ---------------------------------------------------------------------------
// alpha_tensor_issue_queue
//
// In-order issue stage in front of the alphaTensor matrix-multiply pipeline.
// Ops from the IDU are buffered in a small FIFO. The head op issues only when
// neither of its source indices matches a destination still in flight. A
// shift-register scoreboard tracks those in-flight destinations. A branch
// flush drops every queued op that has not issued yet.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   idu_issue_mul_vld             IDU offers an op
//   idu_issue_rd/rs1/rs2          op destination/source matrix indices
//   issue_idu_ready               FIFO not full (registered)
//   iex_issue_bru_vld_0/flush_0   flush when both are high
//   issue_alphaTensor_mul_vld     head op issues this cycle (combinational)
//   issue_alphaTensor_rd/rs1/rs2  head op indices, 0 when the FIFO is empty
//   issue_count                   FIFO occupancy (registered)
//   issue_stall_cnt               saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module alpha_tensor_issue_queue #(
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned INFLIGHT_DEPTH = 3,
    parameter int unsigned IDX_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         idu_issue_mul_vld,
    input  logic [IDX_W-1:0]             idu_issue_rd,
    input  logic [IDX_W-1:0]             idu_issue_rs1,
    input  logic [IDX_W-1:0]             idu_issue_rs2,
    output logic                         issue_idu_ready,
    input  logic                         iex_issue_bru_vld_0,
    input  logic                         iex_issue_bru_flush_0,
    output logic                         issue_alphaTensor_mul_vld,
    output logic [IDX_W-1:0]             issue_alphaTensor_rd,
    output logic [IDX_W-1:0]             issue_alphaTensor_rs1,
    output logic [IDX_W-1:0]             issue_alphaTensor_rs2,
    output logic [$clog2(QUEUE_DEPTH):0] issue_count,
    output logic [31:0]                  issue_stall_cnt
);

    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned STALL_W = 32;

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
    } op_t;

    // FIFO storage and control state
    op_t              fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             ready_q;

    // Scoreboard of destinations still in flight
    logic             sb_vld_q [INFLIGHT_DEPTH];
    logic [IDX_W-1:0] sb_rd_q  [INFLIGHT_DEPTH];

    logic [STALL_W-1:0] stall_cnt_q;

    logic flush;
    logic empty;
    logic hazard;
    logic issue;
    logic enq;
    op_t  head;
    op_t  op_in;

    // Decode of the flush request, occupancy and the head entry
    always_comb begin
        flush = iex_issue_bru_vld_0 && iex_issue_bru_flush_0;
        empty = (count_q == '0);
        head  = fifo_q[rd_ptr_q];
        op_in = '{rd: idu_issue_rd, rs1: idu_issue_rs1, rs2: idu_issue_rs2};
    end

    // RAW check of the head sources against every valid pending write
    always_comb begin
        hazard = 1'b0;
        for (int unsigned k = 0; k < INFLIGHT_DEPTH; k++) begin
            if (sb_vld_q[k] && ((sb_rd_q[k] == head.rs1) || (sb_rd_q[k] == head.rs2))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && !empty;
    end

    // Issue and enqueue qualifiers; ready is registered so a full FIFO
    // never accepts in the same cycle its head leaves
    always_comb begin
        issue = !empty && !hazard && !flush;
        enq   = idu_issue_mul_vld && ready_q && !flush;
    end

    // Next occupancy
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = '0;
        end else if (enq && !issue) begin
            count_next = count_q + CNT_W'(1);
        end else if (!enq && issue) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_next;
            ready_q <= (count_next != CNT_W'(QUEUE_DEPTH));
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (enq) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (issue) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // FIFO payload; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= op_in;
        end
    end

    // Scoreboard shift; not flushed because issued ops still write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < INFLIGHT_DEPTH; k++) begin
                sb_vld_q[k] <= 1'b0;
                sb_rd_q[k]  <= '0;
            end
        end else begin
            sb_vld_q[0] <= issue;
            sb_rd_q[0]  <= head.rd;
            for (int unsigned k = 1; k < INFLIGHT_DEPTH; k++) begin
                sb_vld_q[k] <= sb_vld_q[k-1];
                sb_rd_q[k]  <= sb_rd_q[k-1];
            end
        end
    end

    // Saturating count of hazard-stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_W'(1);
        end
    end

    // Output drive
    always_comb begin
        issue_idu_ready           = ready_q;
        issue_count               = count_q;
        issue_stall_cnt           = stall_cnt_q;
        issue_alphaTensor_mul_vld = issue;
        issue_alphaTensor_rd      = empty ? '0 : head.rd;
        issue_alphaTensor_rs1     = empty ? '0 : head.rs1;
        issue_alphaTensor_rs2     = empty ? '0 : head.rs2;
    end

endmodule

// File: tb/tb_alpha_tensor_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alpha_tensor_issue_queue
//
// Directed bench for alpha_tensor_issue_queue with default parameters.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge, where they reflect the state and inputs of the current cycle.
// ---------------------------------------------------------------------------
module tb_alpha_tensor_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        idu_issue_mul_vld;
    logic [7:0]  idu_issue_rd;
    logic [7:0]  idu_issue_rs1;
    logic [7:0]  idu_issue_rs2;
    logic        issue_idu_ready;
    logic        iex_issue_bru_vld_0;
    logic        iex_issue_bru_flush_0;
    logic        issue_alphaTensor_mul_vld;
    logic [7:0]  issue_alphaTensor_rd;
    logic [7:0]  issue_alphaTensor_rs1;
    logic [7:0]  issue_alphaTensor_rs2;
    logic [2:0]  issue_count;
    logic [31:0] issue_stall_cnt;

    int n_pass;
    int n_total;

    alpha_tensor_issue_queue #(
        .QUEUE_DEPTH   (4),
        .INFLIGHT_DEPTH(3),
        .IDX_W         (8)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .idu_issue_mul_vld        (idu_issue_mul_vld),
        .idu_issue_rd             (idu_issue_rd),
        .idu_issue_rs1            (idu_issue_rs1),
        .idu_issue_rs2            (idu_issue_rs2),
        .issue_idu_ready          (issue_idu_ready),
        .iex_issue_bru_vld_0      (iex_issue_bru_vld_0),
        .iex_issue_bru_flush_0    (iex_issue_bru_flush_0),
        .issue_alphaTensor_mul_vld(issue_alphaTensor_mul_vld),
        .issue_alphaTensor_rd     (issue_alphaTensor_rd),
        .issue_alphaTensor_rs1    (issue_alphaTensor_rs1),
        .issue_alphaTensor_rs2    (issue_alphaTensor_rs2),
        .issue_count              (issue_count),
        .issue_stall_cnt          (issue_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the expected outputs for that cycle
    typedef struct {
        int vld;
        int rd;
        int rs1;
        int rs2;
        int exp_mv;
        int exp_rd;
        int exp_cnt;
        int exp_stall;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(input int vld, input int rd, input int rs1, input int rs2,
                                input int mv, input int erd, input int cnt, input int st);
        vec_t v;
        v.vld = vld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.exp_mv = mv; v.exp_rd = erd; v.exp_cnt = cnt; v.exp_stall = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_iss(input string name, input int mv, input int rd);
        chk({name, "_mv"}, 32'(issue_alphaTensor_mul_vld), 32'(mv));
        chk({name, "_rd"}, 32'(issue_alphaTensor_rd), 32'(rd));
    endtask

    task automatic offer(input int v, input int rd, input int rs1, input int rs2,
                         input int bv, input int bf);
        idu_issue_mul_vld     = 1'(v);
        idu_issue_rd          = 8'(rd);
        idu_issue_rs1         = 8'(rs1);
        idu_issue_rs2         = 8'(rs2);
        iex_issue_bru_vld_0   = 1'(bv);
        iex_issue_bru_flush_0 = 1'(bf);
    endtask

    task automatic idle();
        offer(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int  sent;
        int  got;
        logic acc;

        n_pass  = 0;
        n_total = 0;

        // Independent burst, RAW on rs1, RAW on rs2
        vecs[0]  = mk(1, 1, 10, 11, 0, 0, 0, 0);
        vecs[1]  = mk(1, 2, 10, 11, 1, 1, 1, 0);
        vecs[2]  = mk(1, 3, 10, 11, 1, 2, 1, 0);
        vecs[3]  = mk(1, 4, 10, 11, 1, 3, 1, 0);
        vecs[4]  = mk(0, 0,  0,  0, 1, 4, 1, 0);
        vecs[5]  = mk(0, 0,  0,  0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 5,  1,  2, 0, 0, 0, 0);
        vecs[7]  = mk(1, 6,  5,  3, 1, 5, 1, 0);
        vecs[8]  = mk(0, 0,  0,  0, 0, 6, 1, 0);
        vecs[9]  = mk(0, 0,  0,  0, 0, 6, 1, 1);
        vecs[10] = mk(0, 0,  0,  0, 0, 6, 1, 2);
        vecs[11] = mk(0, 0,  0,  0, 1, 6, 1, 3);
        vecs[12] = mk(1, 7, 20, 21, 0, 0, 0, 3);
        vecs[13] = mk(1, 8, 22,  7, 1, 7, 1, 3);
        vecs[14] = mk(0, 0,  0,  0, 0, 8, 1, 3);
        vecs[15] = mk(0, 0,  0,  0, 0, 8, 1, 4);
        vecs[16] = mk(0, 0,  0,  0, 0, 8, 1, 5);
        vecs[17] = mk(0, 0,  0,  0, 1, 8, 1, 6);
        vecs[18] = mk(0, 0,  0,  0, 0, 0, 0, 6);

        // Power-on reset
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("por_mv",    32'(issue_alphaTensor_mul_vld), 0);
        chk("por_rd",    32'(issue_alphaTensor_rd), 0);
        chk("por_rs1",   32'(issue_alphaTensor_rs1), 0);
        chk("por_rs2",   32'(issue_alphaTensor_rs2), 0);
        chk("por_cnt",   32'(issue_count), 0);
        chk("por_stall", issue_stall_cnt, 0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            offer(vecs[i].vld, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 0, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_mv", i),    32'(issue_alphaTensor_mul_vld), 32'(vecs[i].exp_mv));
            chk($sformatf("vec%0d_rd", i),    32'(issue_alphaTensor_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_cnt", i),   32'(issue_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_rdy", i),   32'(issue_idu_ready), 1);
            chk($sformatf("vec%0d_stall", i), issue_stall_cnt, 32'(vecs[i].exp_stall));
            tick();
        end

        // Reset mid-stream with a stalled op queued
        offer(1, 90, 40, 41, 0, 0); @(negedge clk); tick();
        offer(1, 91, 90, 99, 0, 0); @(negedge clk);
        chk_iss("rst_pre", 1, 90); tick();
        idle(); @(negedge clk);
        chk("rst_stalled_mv",  32'(issue_alphaTensor_mul_vld), 0);
        chk("rst_stalled_cnt", 32'(issue_count), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mv",    32'(issue_alphaTensor_mul_vld), 0);
        chk("rst_rd",    32'(issue_alphaTensor_rd), 0);
        chk("rst_rs1",   32'(issue_alphaTensor_rs1), 0);
        chk("rst_rs2",   32'(issue_alphaTensor_rs2), 0);
        chk("rst_cnt",   32'(issue_count), 0);
        chk("rst_stall", issue_stall_cnt, 0);
        offer(1, 93, 40, 41, 0, 0);
        tick(); @(negedge clk);
        chk("rst_low_mv",  32'(issue_alphaTensor_mul_vld), 0);
        chk("rst_low_cnt", 32'(issue_count), 0);
        tick();
        rst_n = 1'b1;
        // rs1=90 must not hit: the scoreboard was cleared by reset
        offer(1, 92, 90, 99, 0, 0); @(negedge clk);
        chk("rel_rdy", 32'(issue_idu_ready), 1);
        chk("rel_cnt", 32'(issue_count), 0);
        chk("rel_mv",  32'(issue_alphaTensor_mul_vld), 0);
        tick();
        idle(); @(negedge clk);
        chk_iss("rel_first", 1, 92);
        tick();

        // Full FIFO behind a hazard on rd=30
        offer(1, 30, 40, 41, 0, 0); @(negedge clk); tick();
        offer(1, 50, 30, 99, 0, 0); @(negedge clk);
        chk_iss("full_h", 1, 30); tick();
        for (int i = 0; i < 3; i++) begin
            offer(1, 51 + i, 30, 99, 0, 0); @(negedge clk);
            chk("full_stall_mv", 32'(issue_alphaTensor_mul_vld), 0);
            chk("full_fill_cnt", 32'(issue_count), 32'(i + 1));
            chk("full_fill_rdy", 32'(issue_idu_ready), 1);
            tick();
        end
        offer(1, 54, 30, 99, 0, 0); @(negedge clk);
        chk("full_cnt4",  32'(issue_count), 4);
        chk("full_rdy0",  32'(issue_idu_ready), 0);
        chk_iss("full_p0", 1, 50);
        chk("full_p0_rs1", 32'(issue_alphaTensor_rs1), 30);
        chk("full_p0_rs2", 32'(issue_alphaTensor_rs2), 99);
        chk("full_stall",  issue_stall_cnt, 3);
        tick();
        @(negedge clk);
        chk("full_rdy_back", 32'(issue_idu_ready), 1);
        chk("full_cnt3",     32'(issue_count), 3);
        chk_iss("full_p1", 1, 51);
        tick();
        offer(1, 55, 30, 99, 0, 0); @(negedge clk);
        chk_iss("full_p2", 1, 52); tick();
        idle(); @(negedge clk);
        chk_iss("full_p3", 1, 53); tick();
        @(negedge clk); chk_iss("full_p4", 1, 54); tick();
        @(negedge clk); chk_iss("full_p5", 1, 55); tick();
        @(negedge clk);
        chk_iss("full_empty", 0, 0);
        chk("full_empty_cnt", 32'(issue_count), 0);
        tick();

        // Flush with three ops queued and the head stalled
        offer(1, 59, 40, 41, 0, 0); @(negedge clk); tick();
        offer(1, 60, 59, 99, 0, 0); @(negedge clk);
        chk_iss("fl_g", 1, 59); tick();
        offer(1, 61, 60, 99, 0, 0); @(negedge clk);
        chk("fl_h2_wait", 32'(issue_alphaTensor_mul_vld), 0); tick();
        offer(1, 62, 70, 71, 0, 0); @(negedge clk); tick();
        offer(1, 63, 70, 71, 0, 0); @(negedge clk); tick();
        idle(); @(negedge clk);
        chk_iss("fl_h2", 1, 60);
        chk("fl_cnt4",  32'(issue_count), 4);
        chk("fl_stall", issue_stall_cnt, 6);
        tick();
        offer(1, 64, 70, 71, 1, 1); @(negedge clk);
        chk("fl_flush_mv", 32'(issue_alphaTensor_mul_vld), 0);
        chk("fl_flush_cnt", 32'(issue_count), 3);
        tick();
        offer(1, 65, 60, 99, 0, 0); @(negedge clk);
        chk_iss("fl_after", 0, 0);
        chk("fl_after_cnt",   32'(issue_count), 0);
        chk("fl_after_stall", issue_stall_cnt, 6);
        tick();
        idle(); @(negedge clk);
        chk_iss("fl_r_wait", 0, 65);
        chk("fl_r_cnt", 32'(issue_count), 1);
        tick();
        @(negedge clk);
        chk_iss("fl_r_issue", 1, 65);
        chk("fl_r_stall", issue_stall_cnt, 7);
        tick();

        // Flush suppresses an otherwise issuable head
        offer(1, 66, 70, 71, 0, 0); @(negedge clk); tick();
        offer(0, 0, 0, 0, 1, 1); @(negedge clk);
        chk("sup_mv",  32'(issue_alphaTensor_mul_vld), 0);
        chk("sup_cnt", 32'(issue_count), 1);
        tick();
        idle(); @(negedge clk);
        chk_iss("sup_after", 0, 0);
        chk("sup_after_cnt", 32'(issue_count), 0);
        tick();

        // Only both flush inputs high form a flush
        offer(1, 67, 70, 71, 0, 0); @(negedge clk); tick();
        offer(1, 68, 70, 71, 0, 1); @(negedge clk);
        chk_iss("half_flush_a", 1, 67); tick();
        offer(0, 0, 0, 0, 1, 0); @(negedge clk);
        chk_iss("half_flush_b", 1, 68); tick();
        idle(); @(negedge clk);
        chk("half_flush_cnt", 32'(issue_count), 0);
        tick();

        // 37 independent ops through the 4-entry FIFO
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (got >= 37) break;
            if (sent < 37) offer(1, 100 + sent, 200, 201, 0, 0);
            else           idle();
            @(negedge clk);
            acc = (sent < 37) && issue_idu_ready;
            if (issue_alphaTensor_mul_vld) begin
                chk($sformatf("wrap_order%0d", got), 32'(issue_alphaTensor_rd), 32'(100 + got));
                got++;
            end
            tick();
            if (acc) sent++;
        end
        chk("wrap_issued", 32'(got), 37);
        idle(); @(negedge clk);
        chk("wrap_stall", issue_stall_cnt, 7);

        // Stall counter saturation
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        tick();
        offer(1, 80, 40, 41, 0, 0); @(negedge clk);
        chk("sat_pre", issue_stall_cnt, 32'hFFFF_FFFE); tick();
        offer(1, 81, 80, 99, 0, 0); @(negedge clk);
        chk_iss("sat_g", 1, 80); tick();
        idle(); @(negedge clk);
        chk("sat_s0", issue_stall_cnt, 32'hFFFF_FFFE); tick();
        @(negedge clk);
        chk("sat_s1", issue_stall_cnt, 32'hFFFF_FFFF); tick();
        @(negedge clk);
        chk("sat_s2", issue_stall_cnt, 32'hFFFF_FFFF); tick();
        @(negedge clk);
        chk_iss("sat_dep", 1, 81);
        chk("sat_hold", issue_stall_cnt, 32'hFFFF_FFFF);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
